// File: rtl/interp_cmd_sched.sv
// interp_cmd_sched: validates, queues and issues interpolation commands to the engine.
// Optional CMD_TIMEOUT_EN adds a RUN-state watchdog that aborts after TIMEOUT_CYC cycles.
module interp_cmd_sched #(
  parameter int          DEPTH       = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     cmd_valid,
  input  logic [83:0]              cmd_data,
  input  logic                     abort,
  input  logic                     eng_busy,
  input  logic                     eng_done,
  output logic                     eng_start,
  output logic                     eng_abort,
  output logic [83:0]              eng_data,
  output logic                     cmd_drop,
  output logic [1:0]               err_code,
  input  logic                     err_clr,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [1:0]               state
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, RUN = 2'b10} st_t;
  st_t st, st_nx;
  logic cmd_valid_q;
  logic [83:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic [7:0] vmax, acc;
  logic push_req, invalid, full, pop, do_push, bad, ovf, tmo;
  logic unused_ok;
  assign unused_ok = ^{eng_busy, TIMEOUT_CYC};
  assign vmax     = cmd_data[15:8];
  assign acc      = cmd_data[7:0];
  assign push_req = cmd_valid & ~cmd_valid_q;
  assign invalid  = vmax == 8'd0 || acc == 8'd0 || acc > vmax || cmd_data[82:81] == 2'b11;
  assign full     = cnt == (AW+1)'(DEPTH);
  assign pop      = st == IDLE && cnt != '0 && !abort;
  assign bad      = push_req & ~abort & invalid;
  assign ovf      = push_req & ~abort & ~invalid & full & ~pop;
  assign do_push  = push_req & ~abort & ~invalid & (~full | pop);
  assign q_count  = cnt;
  assign state    = st;
`ifdef CMD_TIMEOUT_EN
  logic [23:0] run_cnt;
  // counter idles at zero outside RUN, so it restarts on every entry
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) run_cnt <= '0;
    else run_cnt <= (st == RUN) ? run_cnt + 24'd1 : '0;
  assign tmo = st == RUN && run_cnt == TIMEOUT_CYC - 24'd1 && !eng_done && !abort;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    st_nx     = st;
    eng_start = st == ISSUE;
    eng_abort = (abort && st != IDLE) || tmo;
    st_nx     = abort ? IDLE :
                st == IDLE  ? (pop ? ISSUE : IDLE) :
                st == ISSUE ? RUN :
                (eng_done || tmo) ? IDLE : RUN;
  end
  always_ff @(posedge sys_clk)
    if (do_push) mem[wr_ptr] <= cmd_data;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      st          <= IDLE;
      cmd_valid_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      eng_data    <= '0;
      cmd_drop    <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      st          <= st_nx;
      cmd_valid_q <= cmd_valid;
      cmd_drop    <= bad | ovf;
      wr_ptr      <= abort ? '0 : wr_ptr + AW'(do_push);
      rd_ptr      <= abort ? '0 : rd_ptr + AW'(pop);
      cnt         <= abort ? '0 : cnt + (AW+1)'(do_push) - (AW+1)'(pop);
      if (pop) eng_data <= mem[rd_ptr];
      err_code    <= tmo ? 2'b11 : ovf ? 2'b10 : bad ? 2'b01 : err_clr ? 2'b00 : err_code;
    end
endmodule

// File: tb/tb_interp_cmd_sched.sv
// tb_interp_cmd_sched: scoreboard bench for interp_cmd_sched; define CMD_TIMEOUT_EN to add the watchdog case.
module tb_interp_cmd_sched;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic cmd_valid = 1'b0, abort = 1'b0, eng_busy = 1'b0, eng_done = 1'b0, err_clr = 1'b0;
  logic [83:0] cmd_data = '0;
  logic eng_start, eng_abort, cmd_drop;
  logic [83:0] eng_data;
  logic [1:0] err_code, state;
  logic [2:0] q_count;
  int cyc = 0, n_chk = 0, n_pass = 0;
  typedef struct packed { logic [83:0] d; int c; } exp_t;
  exp_t sq[$];
  logic [1:0] dq[$];

  interp_cmd_sched #(.DEPTH(4), .TIMEOUT_CYC(24'd100)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .abort(abort), .eng_busy(eng_busy), .eng_done(eng_done), .eng_start(eng_start),
    .eng_abort(eng_abort), .eng_data(eng_data), .cmd_drop(cmd_drop), .err_code(err_code),
    .err_clr(err_clr), .q_count(q_count), .state(state)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [83:0] mk(input logic [15:0] s, input logic [1:0] m,
                                     input logic [7:0] v, input logic [7:0] a);
    return {s[0], m, s, s + 16'h0101, ~s, s ^ 16'h5a5a, s[1], v, a};
  endfunction

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic exp_start(input logic [83:0] d, input int c);
    sq.push_back({d, c});
  endtask

  task automatic send(input logic [83:0] d, input logic [1:0] dc, output int k);
    if (dc != 2'b00) dq.push_back(dc);
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick;
    k = cyc;
    cmd_valid = 1'b0;
    tick;
  endtask

  task automatic done_pulse(output int m);
    eng_done = 1'b1;
    tick;
    m = cyc;
    eng_done = 1'b0;
  endtask

  // monitor: every start and drop must match the next scoreboard entry
  always @(negedge sys_clk) begin
    if (!sys_rst && eng_start) begin
      if (sq.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        exp_t e;
        e = sq.pop_front();
        chk("eng_data", eng_data, e.d);
        if (e.c >= 0) chk("start_cycle", cyc, e.c);
      end
    end
    if (!sys_rst && cmd_drop) begin
      if (dq.size() == 0) chk("unexpected_drop", 1, 0);
      else chk("drop_err_code", err_code, dq.pop_front());
    end
  end

  logic [83:0] b [5];
  initial begin
    int k, m, hc;
    tick;
    tick;
    sys_rst = 1'b0;
    tick;
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_abort", eng_abort, 0);
    chk("rst_cmd_drop", cmd_drop, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_state", state, 0);
    chk("rst_eng_data", eng_data, 0);

    cmd_data  = mk(16'h1234, 2'b00, 8'h20, 8'h04);
    cmd_valid = 1'b1;
    tick;
    exp_start(cmd_data, cyc + 1);
    cmd_valid = 1'b0;
    chk("single_q1", q_count, 1);
    tick;
    chk("single_q0", q_count, 0);
    chk("single_issue", state, 1);
    tick;
    chk("single_run", state, 2);
    done_pulse(m);
    chk("single_idle", state, 0);

    cmd_data  = mk(16'hbeef, 2'b01, 8'h10, 8'h10);
    cmd_valid = 1'b1;
    tick;
    exp_start(cmd_data, cyc + 1);
    repeat (49) tick;
    cmd_valid = 1'b0;
    tick;
    chk("held_run", state, 2);
    chk("held_q", q_count, 0);
    done_pulse(m);

    send(mk(16'h0030, 2'b00, 8'h20, 8'h30), 2'b01, k);
    send(mk(16'h0031, 2'b11, 8'h20, 8'h04), 2'b01, k);
    send(mk(16'h0032, 2'b10, 8'h00, 8'h00), 2'b01, k);
    tick;
    chk("inv_q", q_count, 0);
    chk("inv_state", state, 0);
    chk("inv_err", err_code, 1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("inv_clr", err_code, 0);

    eng_busy = 1'b1;
    cmd_data = mk(16'h4040, 2'b01, 8'h40, 8'h40);
    send(cmd_data, 2'b00, k);
    exp_start(mk(16'h4040, 2'b01, 8'h40, 8'h40), k + 1);
    tick;
    chk("stall_run", state, 2);
    for (int i = 0; i < 5; i++) begin
      b[i] = mk(16'h0100 * (i + 1) + 16'h7, 2'b10, 8'h80, 8'h10);
      send(b[i], (i == 4) ? 2'b10 : 2'b00, k);
    end
    chk("ovf_q", q_count, 4);
    chk("ovf_err", err_code, 2);
    chk("ovf_state", state, 2);
    for (int i = 0; i < 4; i++) begin
      done_pulse(m);
      exp_start(b[i], m + 1);
      tick;
      tick;
      chk("b2b_run", state, 2);
    end
    chk("b2b_q", q_count, 0);

    for (int i = 0; i < 3; i++) send(mk(16'hc000 + 16'(i), 2'b00, 8'h30, 8'h03), 2'b00, k);
    chk("abort_pre_q", q_count, 3);
    abort     = 1'b1;
    eng_done  = 1'b1;
    cmd_data  = mk(16'hc003, 2'b00, 8'h30, 8'h03);
    cmd_valid = 1'b1;
    #1;
    chk("abort_pulse", eng_abort, 1);
    tick;
    abort     = 1'b0;
    eng_done  = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_q", q_count, 0);
    chk("abort_state", state, 0);
    chk("abort_pulse_end", eng_abort, 0);
    repeat (3) tick;
    done_pulse(m);
    repeat (3) tick;
    chk("late_done_state", state, 0);
    chk("abort_err_kept", err_code, 2);
    eng_busy = 1'b0;

    send(mk(16'h5555, 2'b00, 8'h50, 8'h05), 2'b00, k);
    exp_start(mk(16'h5555, 2'b00, 8'h50, 8'h05), k + 1);
    tick;
    done_pulse(m);
    tick;

    cmd_data  = mk(16'h6666, 2'b00, 8'h60, 8'h06);
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    chk("rst_mid_q1", q_count, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_mid_q", q_count, 0);
    chk("rst_mid_state", state, 0);
    chk("rst_mid_err", err_code, 0);
    sys_rst = 1'b0;
    repeat (3) tick;
    chk("rst_mid_idle", state, 0);

`ifdef CMD_TIMEOUT_EN
    send(mk(16'h7777, 2'b00, 8'h70, 8'h07), 2'b00, k);
    exp_start(mk(16'h7777, 2'b00, 8'h70, 8'h07), k + 1);
    send(mk(16'h8888, 2'b00, 8'h80, 8'h08), 2'b00, m);
    exp_start(mk(16'h8888, 2'b00, 8'h80, 8'h08), -1);
    hc = -1;
    for (int i = 0; i < 300 && hc < 0; i++) begin
      tick;
      if (eng_abort) hc = cyc;
    end
    chk("tmo_cycle", hc, k + 101);
    tick;
    chk("tmo_err", err_code, 3);
    chk("tmo_state", state, 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("tmo_clr", err_code, 0);
    repeat (2) tick;
    chk("tmo_next_run", state, 2);
    done_pulse(m);
`endif

    repeat (5) tick;
    chk("sb_start_left", sq.size(), 0);
    chk("sb_drop_left", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
